// File: rtl/sram_arb_pkg.sv
// Shared definitions for the cartridge SRAM arbiter: FSM state encoding,
// owner encoding and the wait-state counter width.
package sram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      STROBE = 2'd2,
      DONE   = 2'd3
   } state_e;

   localparam logic OWNER_SNES = 1'b0;
   localparam logic OWNER_AVR  = 1'b1;

   // Wide enough for WAIT_CYCLES-1 with WAIT_CYCLES up to 15.
   localparam int CNT_W = 4;

endpackage

// File: rtl/sram_arb_pick.sv
// Combinational grant decision. On a tie the port that was not granted
// last wins; the fixed-priority build ties last_grant_i to AVR, which
// makes SNES win every tie.
module sram_arb_pick
   import sram_arb_pkg::*;
(
   input  logic snes_req_i,
   input  logic avr_req_i,
   input  logic last_grant_i,
   output logic gnt_vld_o,
   output logic gnt_owner_o
);

   // Pick the winner among the active requests.
   always_comb begin
      gnt_vld_o   = snes_req_i | avr_req_i;
      gnt_owner_o = OWNER_SNES;
      if (snes_req_i && avr_req_i)
         gnt_owner_o = (last_grant_i == OWNER_SNES) ? OWNER_AVR : OWNER_SNES;
      else if (avr_req_i)
         gnt_owner_o = OWNER_AVR;
   end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port (SNES / AVR) arbiter for the single cartridge SRAM. Latches the
// winner's request, sequences CE/OE/WE with WAIT_CYCLES strobe cycles and
// returns a one-cycle ack plus read data. All outputs are registered.
// Optional: define SRAM_ARB_ROUND_ROBIN_EN for alternating tie-breaks.
module sram_arbiter
   import sram_arb_pkg::*;
#(
   parameter int AWIDTH      = 19,
   parameter int DWIDTH      = 8,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk_i,
   input  logic              reset_ni,
   input  logic              snes_req_i,
   input  logic              snes_we_i,
   input  logic [AWIDTH-1:0] snes_addr_i,
   input  logic [DWIDTH-1:0] snes_wdata_i,
   output logic [DWIDTH-1:0] snes_rdata_o,
   output logic              snes_ack_o,
   input  logic              avr_req_i,
   input  logic              avr_we_i,
   input  logic [AWIDTH-1:0] avr_addr_i,
   input  logic [DWIDTH-1:0] avr_wdata_i,
   output logic [DWIDTH-1:0] avr_rdata_o,
   output logic              avr_ack_o,
   output logic [AWIDTH-1:0] sram_addr_o,
   output logic [DWIDTH-1:0] sram_dout_o,
   input  logic [DWIDTH-1:0] sram_din_i,
   output logic              sram_dout_en_o,
   output logic              sram_ce_n_o,
   output logic              sram_oe_n_o,
   output logic              sram_we_n_o,
   output logic              busy_o,
   output logic              owner_o
);

   localparam logic [CNT_W-1:0] CntLoad = CNT_W'(WAIT_CYCLES - 1);

   state_e            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              we_q, owner_q, busy_q;
   logic              ce_n_q, oe_n_q, we_n_q, dout_en_q;
   logic              snes_ack_q, avr_ack_q;
   logic [AWIDTH-1:0] addr_q;
   logic [DWIDTH-1:0] dout_q, snes_rdata_q, avr_rdata_q;

   logic              last_grant;
   logic              gnt_vld, gnt_owner;
   logic              gnt_we_d;
   logic [AWIDTH-1:0] gnt_addr_d;
   logic [DWIDTH-1:0] gnt_wdata_d;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
   logic last_grant_q;
   assign last_grant = last_grant_q;
`else
   assign last_grant = OWNER_AVR;
`endif

   sram_arb_pick u_pick (
      .snes_req_i   (snes_req_i),
      .avr_req_i    (avr_req_i),
      .last_grant_i (last_grant),
      .gnt_vld_o    (gnt_vld),
      .gnt_owner_o  (gnt_owner)
   );

   // Request fields of the port that wins this cycle.
   always_comb begin
      gnt_we_d    = snes_we_i;
      gnt_addr_d  = snes_addr_i;
      gnt_wdata_d = snes_wdata_i;
      if (gnt_owner == OWNER_AVR) begin
         gnt_we_d    = avr_we_i;
         gnt_addr_d  = avr_addr_i;
         gnt_wdata_d = avr_wdata_i;
      end
   end

   // Transaction FSM; every strobe/ack output is set one state ahead so it is registered.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         we_q         <= 1'b0;
         owner_q      <= OWNER_SNES;
         busy_q       <= 1'b0;
         ce_n_q       <= 1'b1;
         oe_n_q       <= 1'b1;
         we_n_q       <= 1'b1;
         dout_en_q    <= 1'b0;
         snes_ack_q   <= 1'b0;
         avr_ack_q    <= 1'b0;
         addr_q       <= '0;
         dout_q       <= '0;
         snes_rdata_q <= '0;
         avr_rdata_q  <= '0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
         last_grant_q <= OWNER_AVR;
`endif
      end else begin
         snes_ack_q <= 1'b0;
         avr_ack_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (gnt_vld) begin
                  state_q   <= SETUP;
                  owner_q   <= gnt_owner;
                  we_q      <= gnt_we_d;
                  addr_q    <= gnt_addr_d;
                  dout_q    <= gnt_wdata_d;
                  busy_q    <= 1'b1;
                  ce_n_q    <= 1'b0;
                  oe_n_q    <= gnt_we_d;
                  dout_en_q <= gnt_we_d;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
                  last_grant_q <= gnt_owner;
`endif
               end
            end
            SETUP: begin
               state_q <= STROBE;
               cnt_q   <= CntLoad;
               if (we_q) we_n_q <= 1'b0;
            end
            STROBE: begin
               if (cnt_q == '0) begin
                  state_q <= DONE;
                  we_n_q  <= 1'b1;
                  oe_n_q  <= 1'b1;
                  if (!we_q) begin
                     if (owner_q == OWNER_AVR) avr_rdata_q  <= sram_din_i;
                     else                      snes_rdata_q <= sram_din_i;
                  end
                  if (owner_q == OWNER_AVR) avr_ack_q  <= 1'b1;
                  else                      snes_ack_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            DONE: begin
               state_q   <= IDLE;
               ce_n_q    <= 1'b1;
               dout_en_q <= 1'b0;
               busy_q    <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign snes_rdata_o   = snes_rdata_q;
   assign snes_ack_o     = snes_ack_q;
   assign avr_rdata_o    = avr_rdata_q;
   assign avr_ack_o      = avr_ack_q;
   assign sram_addr_o    = addr_q;
   assign sram_dout_o    = dout_q;
   assign sram_dout_en_o = dout_en_q;
   assign sram_ce_n_o    = ce_n_q;
   assign sram_oe_n_o    = oe_n_q;
   assign sram_we_n_o    = we_n_q;
   assign busy_o         = busy_q;
   assign owner_o        = owner_q;

endmodule
